// File: rtl/radar_point_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : radar_point_buffer
//  Purpose  : First-word-fall-through FIFO that stores cleaned radar points
//             tagged with their frame-end marker. Overflowing writes are
//             dropped, never retagged. Optional per-frame statistics
//             (drop_count, frame_points) are built only when the macro
//             RADAR_BUF_STATS_EN is defined; otherwise both ports read 0.
//  Revision : 1.0 - initial release
// ============================================================================
module radar_point_buffer #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    input  logic [127:0]  clean_point,
    input  logic          frame_end,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_point,
    output logic          out_last,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic [15:0]   drop_count,
    output logic [15:0]   frame_points
);

    localparam int AW = $clog2(DEPTH);

    // Storage entry is {frame_end, clean_point}; not reset, only pointers are.
    logic [128:0]   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           wr_en;
    logic           rd_en;
    logic [128:0]   head;

    // Flags come straight from the registered occupancy.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;
    assign count     = count_q;

    // A full FIFO drops the incoming point even if a pop happens this cycle.
    assign wr_en = valid_in & ~full;
    assign rd_en = out_valid & out_ready;

    // Head presentation is masked to zero while empty so stale storage never leaks.
    assign head      = mem_q[rd_ptr_q];
    assign out_point = empty ? 128'd0 : head[127:0];
    assign out_last  = empty ? 1'b0   : head[128];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {frame_end, clean_point};
        end
    end

`ifdef RADAR_BUF_STATS_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] drop_q, drop_d;
    logic [15:0] frame_q, frame_d;
    logic [15:0] acc_inc;

    assign acc_inc = (acc_q == 16'hFFFF) ? acc_q : acc_q + 16'd1;

    // Frame accumulator, frame length capture and saturating drop counter.
    always_comb begin
        acc_d   = acc_q;
        drop_d  = drop_q;
        frame_d = frame_q;
        if (valid_in && full && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
        if (valid_in && frame_end) begin
            frame_d = wr_en ? acc_inc : acc_q;
            acc_d   = '0;
        end else if (wr_en) begin
            acc_d = acc_inc;
        end
    end

    // Statistics registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            drop_q  <= '0;
            frame_q <= '0;
        end else begin
            acc_q   <= acc_d;
            drop_q  <= drop_d;
            frame_q <= frame_d;
        end
    end

    assign drop_count   = drop_q;
    assign frame_points = frame_q;
`else
    assign drop_count   = 16'd0;
    assign frame_points = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_radar_point_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_radar_point_buffer
//  Purpose  : Scoreboard bench for radar_point_buffer. A queue-based model
//             tracks occupancy and statistics; accepted points are pushed into
//             a scoreboard and a negedge monitor compares presented heads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_radar_point_buffer;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in = 1'b0;
    logic [127:0]  clean_point = '0;
    logic          frame_end = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  out_point;
    logic          out_last;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [15:0]   drop_count;
    logic [15:0]   frame_points;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [128:0] sb_q[$];
    int m_cnt  = 0;
    int m_acc  = 0;
    int m_drop = 0;
    int m_fp   = 0;

    radar_point_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .clean_point(clean_point),
        .frame_end(frame_end), .out_valid(out_valid), .out_ready(out_ready),
        .out_point(out_point), .out_last(out_last), .count(count), .full(full),
        .empty(empty), .drop_count(drop_count), .frame_points(frame_points)
    );

    always #5 clk = ~clk;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: occupancy/statistics from the acceptance rules; pushes accepted points.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q.delete();
            m_cnt = 0; m_acc = 0; m_drop = 0; m_fp = 0;
        end else begin
            bit w, p;
            w = valid_in && (m_cnt < DEPTH);
            p = (m_cnt > 0) && out_ready;
            if (valid_in && frame_end) begin
                m_fp  = w ? sat16(m_acc + 1) : m_acc;
                m_acc = 0;
            end else if (w) begin
                m_acc = sat16(m_acc + 1);
            end
            if (valid_in && !w) m_drop = sat16(m_drop + 1);
            if (w) sb_q.push_back({frame_end, clean_point});
            m_cnt = m_cnt + int'(w) - int'(p);
        end
    end

    // Monitor: compare presented state and head, consume on handshake.
    always @(negedge clk) begin
        chk("count", 128'(count), 128'(m_cnt));
        chk("out_valid", 128'(out_valid), 128'(m_cnt > 0));
        chk("full", 128'(full), 128'(m_cnt == DEPTH));
        chk("empty", 128'(empty), 128'(m_cnt == 0));
`ifdef RADAR_BUF_STATS_EN
        chk("drop_count", 128'(drop_count), 128'(m_drop));
        chk("frame_points", 128'(frame_points), 128'(m_fp));
`else
        chk("drop_count", 128'(drop_count), 128'd0);
        chk("frame_points", 128'(frame_points), 128'd0);
`endif
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 128'd1, 128'd0);
            end else begin
                chk("out_point", out_point, sb_q[0][127:0]);
                chk("out_last", 128'(out_last), 128'(sb_q[0][128]));
                if (out_ready) void'(sb_q.pop_front());
            end
        end else begin
            chk("out_point_idle", out_point, 128'd0);
            chk("out_last_idle", 128'(out_last), 128'd0);
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Applies one cycle of stimulus just after the rising edge.
    task automatic drive(input logic v, input logic fe, input logic rdy);
        @(posedge clk);
        #1;
        valid_in    = v;
        frame_end   = fe;
        out_ready   = rdy;
        clean_point = rnd128();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (m_cnt > 0 && n < budget) begin
            drive(1'b0, 1'b0, 1'b1);
            n++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (m_cnt != 0) begin
            errors++;
            $display("FAIL drain_timeout: count %0d expected 0", m_cnt);
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", 128'(count), 128'd0);
        chk("reset_empty", 128'(empty), 128'd1);
        chk("reset_valid", 128'(out_valid), 128'd0);
        reset = 1'b1;

        // Three points, last one closes the frame, downstream always ready.
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drain(20);

        // Fill beyond capacity with downstream stalled.
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, (i == 5), 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        // Full with simultaneous write and pop: pop happens, write dropped.
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drain(40);

        // Continuous streaming with an asynchronous reset mid-stream.
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, (i % 7 == 6), 1'b1);
            if (i == 20) begin
                #2;
                reset = 1'b0;
                #1;
                chk("async_rst_valid", 128'(out_valid), 128'd0);
                chk("async_rst_count", 128'(count), 128'd0);
                @(posedge clk); #1;
                valid_in = 1'b0;
                reset    = 1'b1;
            end
        end
        drain(40);

        // Randomized traffic with backpressure.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 8)));
        end
        drain(60);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
